// File: rtl/fir_wb_sequencer.sv
// Wishbone master that runs one complete FIR job on fir_wrapper:
// load taps, program length, start, stream X/Y samples, poll ap_done.
module fir_wb_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_3000,
    parameter int          NUM_TAPS  = 11,
    parameter logic [11:0] TAP_OFS   = 12'h020,
    parameter logic [11:0] LEN_OFS   = 12'h010,
    parameter logic [11:0] CTRL_OFS  = 12'h000,
    parameter logic [11:0] STRM_OFS  = 12'h080,
    parameter int          TIMEOUT   = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [31:0] cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  coef_idx,
    input  logic [31:0] coef_data,
    input  logic        x_tvalid,
    input  logic [31:0] x_tdata,
    output logic        x_tready,
    output logic        y_tvalid,
    output logic [31:0] y_tdata,
    input  logic        y_tready,
    output logic        wbm_valid,
    output logic        wbm_we,
    output logic [3:0]  wbm_sel,
    output logic [31:0] wbm_adr,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TAP,
        S_LEN,
        S_GO,
        S_XW,
        S_YR,
        S_YH,
        S_POLL,
        S_FIN,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [31:0]   len_q;
    logic [31:0]   cnt_q;
    logic [31:0]   cnt_d;
    logic [3:0]    idx_q;
    logic [3:0]    idx_d;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          y_tvalid_q;
    logic [31:0]   y_tdata_q;
    logic          valid_q;
    logic          we_q;
    logic [31:0]   adr_q;
    logic [31:0]   dat_q;

    logic          req_go;
    logic          req_we;
    logic [31:0]   req_adr;
    logic [31:0]   req_dat;
    logic          issue;
    logic          ack_ev;
    logic          tmo_hit;
    logic          last_tap;

    assign cnt_d    = cnt_q + 32'd1;
    assign idx_d    = idx_q + 4'd1;
    assign tmo_d    = tmo_q + 1'b1;
    assign last_tap = (idx_q == 4'(NUM_TAPS - 1));

    // Request decode: what transaction the current state wants to launch.
    always_comb begin
        req_go  = 1'b0;
        req_we  = 1'b0;
        req_adr = 32'd0;
        req_dat = 32'd0;
        unique case (state_q)
            S_TAP: begin
                req_go  = 1'b1;
                req_we  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, TAP_OFS} + {26'd0, idx_q, 2'b00};
                req_dat = coef_data;
            end
            S_LEN: begin
                req_go  = 1'b1;
                req_we  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, LEN_OFS};
                req_dat = len_q;
            end
            S_GO: begin
                req_go  = 1'b1;
                req_we  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, CTRL_OFS};
                req_dat = 32'h1;
            end
            S_XW: begin
                req_go  = x_tvalid;
                req_we  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, STRM_OFS};
                req_dat = x_tdata;
            end
            S_YR: begin
                req_go  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, STRM_OFS};
            end
            S_POLL: begin
                req_go  = 1'b1;
                req_adr = BASE_ADDR + {20'd0, CTRL_OFS};
            end
            default: ;
        endcase
    end

    // A new transaction launches only after the bus has gone idle, so the
    // slave always sees at least one cycle of wbm_valid low between cycles.
    assign issue   = req_go && !valid_q;
    assign ack_ev  = valid_q && wbm_ack;
    assign tmo_hit = valid_q && !wbm_ack && (tmo_q == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            len_q      <= 32'd0;
            cnt_q      <= 32'd0;
            idx_q      <= 4'd0;
            tmo_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            y_tvalid_q <= 1'b0;
            y_tdata_q  <= 32'd0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
        end else begin
            done_q <= 1'b0;

            if (issue) begin
                valid_q <= 1'b1;
                we_q    <= req_we;
                adr_q   <= req_adr;
                dat_q   <= req_dat;
                tmo_q   <= '0;
            end else if (ack_ev) begin
                valid_q <= 1'b0;
            end else if (valid_q) begin
                tmo_q <= tmo_d;
            end

            if (tmo_hit) begin
                valid_q <= 1'b0;
                state_q <= S_ERR;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            len_q   <= cfg_len;
                            err_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            cnt_q   <= 32'd0;
                            idx_q   <= 4'd0;
                            state_q <= (cfg_len == 32'd0) ? S_FIN : S_TAP;
                        end
                    end
                    S_TAP: begin
                        if (ack_ev) begin
                            if (last_tap) begin
                                idx_q   <= 4'd0;
                                state_q <= S_LEN;
                            end else begin
                                idx_q <= idx_d;
                            end
                        end
                    end
                    S_LEN: if (ack_ev) state_q <= S_GO;
                    S_GO:  if (ack_ev) state_q <= S_XW;
                    S_XW:  if (ack_ev) state_q <= S_YR;
                    S_YR: begin
                        if (ack_ev) begin
                            y_tdata_q  <= wbm_dat_i;
                            y_tvalid_q <= 1'b1;
                            state_q    <= S_YH;
                        end
                    end
                    S_YH: begin
                        if (y_tready) begin
                            y_tvalid_q <= 1'b0;
                            cnt_q      <= cnt_d;
                            state_q    <= (cnt_d == len_q) ? S_POLL : S_XW;
                        end
                    end
                    S_POLL: begin
                        if (ack_ev && wbm_dat_i[1]) state_q <= S_FIN;
                    end
                    S_FIN: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    S_ERR: begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // The sample is taken on the same edge the stream write launches.
    assign x_tready  = (state_q == S_XW) && !valid_q && x_tvalid;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign coef_idx  = idx_q;
    assign y_tvalid  = y_tvalid_q;
    assign y_tdata   = y_tdata_q;
    assign wbm_valid = valid_q;
    assign wbm_we    = we_q;
    assign wbm_sel   = 4'hF;
    assign wbm_adr   = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
